// File: rtl/core_arf_wb.sv
// core_arf_wb: in-order writeback buffer in front of the architectural
// register file write port. Requests are queued, drained to the ARF in
// acceptance order, and can be looked up so the read side can forward
// values that have not been committed yet. Writes to R0 are dropped.
module core_arf_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [AW-1:0]              in_addr_i,
    input  logic [DW-1:0]              in_data_i,
    output logic                       w_en_o,
    output logic [AW-1:0]              w_addr_o,
    output logic [DW-1:0]              w_data_o,
    input  logic                       w_stall_i,
    input  logic [AW-1:0]              q_addr_i,
    output logic                       q_hit_o,
    output logic [DW-1:0]              q_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic             push;
    logic             pop;
    logic             not_empty;
    logic [DEPTH-1:0] match;

    // Ready depends only on registered occupancy, never on the stall input.
    assign in_ready_o = (count_reg < CW'(DEPTH));
    // R0 requests complete the handshake but are silently consumed.
    assign push       = in_valid_i & in_ready_o & (in_addr_i != '0);
    assign not_empty  = (count_reg != '0);
    assign w_en_o     = not_empty & ~w_stall_i;
    assign pop        = w_en_o;
    assign w_addr_o   = not_empty ? addr_mem[rd_ptr_reg] : '0;
    assign w_data_o   = not_empty ? data_mem[rd_ptr_reg] : '0;
    assign count_o    = count_reg;

    // Pointer, occupancy and entry-valid bookkeeping; reset discards everything.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            // Push and pop never target the same slot: that would need the
            // buffer to be both empty (no pop) and full (no push).
            if (push) begin
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage; contents are qualified by valid_reg so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= in_addr_i;
            data_mem[wr_ptr_reg] <= in_data_i;
        end
    end

    // Per-slot address comparators for the forwarding lookup.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (addr_mem[gi] == q_addr_i)
                               && (q_addr_i != '0);
        end
    endgenerate

    // Scan from head to tail so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] scan_idx;
        q_hit_o  = 1'b0;
        q_data_o = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_reg + PW'(k);
            if (match[scan_idx]) begin
                q_hit_o  = 1'b1;
                q_data_o = data_mem[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_core_arf_wb.sv
// Testbench for core_arf_wb: a queue model of pending writes predicts
// occupancy, handshake, ARF writes (in order) and forwarding lookups.
module tb_core_arf_wb;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] in_addr_i;
    logic [DW-1:0] in_data_i;
    logic          w_en_o;
    logic [AW-1:0] w_addr_o;
    logic [DW-1:0] w_data_o;
    logic          w_stall_i;
    logic [AW-1:0] q_addr_i;
    logic          q_hit_o;
    logic [DW-1:0] q_data_o;
    logic [2:0]    count_o;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] sb[$];

    core_arf_wb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_addr_i  (in_addr_i),
        .in_data_i  (in_data_i),
        .w_en_o     (w_en_o),
        .w_addr_o   (w_addr_o),
        .w_data_o   (w_data_o),
        .w_stall_i  (w_stall_i),
        .q_addr_i   (q_addr_i),
        .q_hit_o    (q_hit_o),
        .q_data_o   (q_data_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // mid-cycle against the model, then update the model for the next edge.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic st, input logic [AW-1:0] qa, input logic rs);
        int            exp_cnt;
        logic          exp_ready;
        logic          exp_wen;
        logic          exp_hit;
        logic [DW-1:0] exp_qd;
        in_valid_i = v;
        in_addr_i  = a;
        in_data_i  = d;
        w_stall_i  = st;
        q_addr_i   = qa;
        srst_i     = rs;
        #2;
        exp_cnt   = sb.size();
        exp_ready = (exp_cnt < DEPTH);
        exp_wen   = (exp_cnt != 0) && !st;
        exp_hit   = 1'b0;
        exp_qd    = '0;
        if (qa != 0) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i][AW+DW-1:DW] == qa) begin
                    exp_hit = 1'b1;
                    exp_qd  = sb[i][DW-1:0];
                    break;
                end
            end
        end
        check_eq("count", count_o, exp_cnt);
        check_eq("in_ready", in_ready_o, exp_ready);
        check_eq("w_en", w_en_o, exp_wen);
        check_eq("q_hit", q_hit_o, exp_hit);
        check_eq("q_data", q_data_o, exp_qd);
        if (exp_cnt == 0) begin
            check_eq("w_addr_idle", w_addr_o, 0);
            check_eq("w_data_idle", w_data_o, 0);
        end else begin
            check_eq("w_addr_head", w_addr_o, sb[0][AW+DW-1:DW]);
            check_eq("w_data_head", w_data_o, sb[0][DW-1:0]);
        end
        if (rs) begin
            $display("t=%0t reset, %0d pending discarded", $time, sb.size());
            sb.delete();
        end else begin
            if (exp_wen) begin
                $display("t=%0t arf write R%0d = %h", $time, w_addr_o, w_data_o);
                void'(sb.pop_front());
            end
            if (v && exp_ready) begin
                $display("t=%0t accept R%0d = %h", $time, a, d);
                if (a != 0) sb.push_back({a, d});
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        logic [AW-1:0] ta;
        logic [DW-1:0] td;
        srst_i     = 1'b1;
        in_valid_i = 1'b0;
        in_addr_i  = '0;
        in_data_i  = '0;
        w_stall_i  = 1'b0;
        q_addr_i   = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Reset state, then a single write and its forwarding window.
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b0);

        // Fill under stall; fifth request waits for the first pop.
        for (int i = 1; i <= 5; i++) begin
            ta = 4'(i);
            td = 16'(i * 16'h0011);
            step(1'b1, ta, td, 1'b1, 4'd2, 1'b0);
        end
        step(1'b1, 4'd5, 16'h0055, 1'b0, 4'd5, 1'b0);
        step(1'b1, 4'd5, 16'h0055, 1'b0, 4'd5, 1'b0);
        repeat (6) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 1'b0);

        // Repeated writes to one register: youngest forwarded, both committed.
        step(1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd7, 16'hBBBB, 1'b1, 4'd7, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0);
        repeat (3) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 1'b0);

        // R0 is consumed but never written or forwarded.
        step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0);
        repeat (2) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0);

        // Streaming push and pop across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            ta = 4'((i % 15) + 1);
            td = 16'(16'h0101 * (i + 1));
            step(1'b1, ta, td, 1'b0, 4'(((i + 14) % 15) + 1), 1'b0);
        end
        repeat (2) step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd12, 1'b0);

        // Reset with three pending and a request presented.
        step(1'b1, 4'd1, 16'h0101, 1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 16'h0202, 1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd3, 16'h0303, 1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd9, 16'h9999, 1'b1, 4'd1, 1'b1);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd9, 1'b0);
        step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
